// File: rtl/rr_onehot_arbiter.sv
// 8-way round-robin arbiter whose registered grant is always zero or one-hot, feeding an 8-to-3 encoder.
// Latency: request to grant is 1 cycle; each grant is followed by at least one idle cycle.
// Backpressure: none; the owner holds its grant until it drops req or MAX_HOLD cycles expire.
module rr_onehot_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic         timeout
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] owner;
    logic [PW-1:0] owner_nxt;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_cnt_nxt;
    logic [N-1:0]  grant_nxt;
    logic          timeout_nxt;

    logic [N-1:0]  rot_req;
    logic [PW-1:0] pick;
    logic          pick_vld;
    logic          owner_req;
    logic          hold_done;
    logic          release_own;

    // rot_req[i] is the request that sits i positions after the pointer.
    always_comb begin
        rot_req = '0;
        for (int i = 0; i < N; i++) begin
            rot_req[i] = req[(int'(ptr) + i) % N];
        end
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                pick     = PW'((int'(ptr) + i) % N);
                pick_vld = 1'b1;
            end
        end
    end

    assign owner_req   = req[owner];
    assign hold_done   = (hold_cnt == CW'(MAX_HOLD));
    assign release_own = !owner_req || hold_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            owner       <= owner_nxt;
            hold_cnt    <= hold_cnt_nxt;
            grant       <= grant_nxt;
            grant_valid <= |grant_nxt;
            timeout     <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_vld) state_nxt = OWN;
            OWN:  if (release_own) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        hold_cnt_nxt = hold_cnt;
        grant_nxt    = grant;
        timeout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                grant_nxt    = '0;
                hold_cnt_nxt = '0;
                if (pick_vld) begin
                    owner_nxt       = pick;
                    hold_cnt_nxt    = CW'(1);
                    grant_nxt[pick] = 1'b1;
                end
            end
            OWN: begin
                if (release_own) begin
                    // A force-released owner drops to lowest priority in the next scan.
                    grant_nxt    = '0;
                    hold_cnt_nxt = '0;
                    ptr_nxt      = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
                    timeout_nxt  = owner_req && hold_done;
                end else begin
                    hold_cnt_nxt = hold_cnt + CW'(1);
                end
            end
            default: begin
                grant_nxt    = '0;
                hold_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: a cycle table on a MAX_HOLD=16 instance plus
// hand sequences for hold-limit, rotation and simultaneous-release cases.
module tb_rr_onehot_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req16;
    logic [7:0] req4;
    logic [7:0] g16;
    logic [7:0] g4;
    logic       v16;
    logic       v4;
    logic       t16;
    logic       t4;
    logic       chk_en = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rr_onehot_arbiter #(.N(8), .MAX_HOLD(16)) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req16),
        .grant       (g16),
        .grant_valid (v16),
        .timeout     (t16)
    );

    rr_onehot_arbiter #(.N(8), .MAX_HOLD(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req4),
        .grant       (g4),
        .grant_valid (v4),
        .timeout     (t4)
    );

    always @(posedge clk) begin
        if (chk_en) begin
            assert ($onehot0(g16)) else $error("grant16 not onehot0: %h", g16);
            assert ($onehot0(g4)) else $error("grant4 not onehot0: %h", g4);
        end
    end

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] grant;
        logic       vld;
        logic       tmo;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [7:0] q, input logic [7:0] g,
                       input logic v, input logic t);
        vec_t e;
        e.rst_n = r;
        e.req   = q;
        e.grant = g;
        e.vld   = v;
        e.tmo   = t;
        tbl.push_back(e);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
    endtask

    task automatic chk4(input string nm, input logic [7:0] g, input logic v, input logic t);
        check({nm, " grant"}, g4, g);
        check({nm, " valid"}, {7'd0, v4}, {7'd0, v});
        check({nm, " timeout"}, {7'd0, t4}, {7'd0, t});
    endtask

    task automatic chk16(input string nm, input logic [7:0] g, input logic v, input logic t);
        check({nm, " grant"}, g16, g);
        check({nm, " valid"}, {7'd0, v16}, {7'd0, v});
        check({nm, " timeout"}, {7'd0, t16}, {7'd0, t});
    endtask

    initial begin
        rst_n = 1'b0;
        req16 = 8'hFF;
        req4  = 8'h00;

        // reset held with all requests up
        add(0, 8'hFF, 8'h00, 0, 0);
        add(0, 8'hFF, 8'h00, 0, 0);
        add(0, 8'hFF, 8'h00, 0, 0);
        add(1, 8'hFF, 8'h01, 1, 0);
        add(1, 8'h00, 8'h00, 0, 0);
        // single request held 5 cycles, then ptr=3 check via 0x09
        for (int i = 0; i < 5; i++) add(1, 8'h04, 8'h04, 1, 0);
        add(1, 8'h00, 8'h00, 0, 0);
        add(1, 8'h09, 8'h08, 1, 0);
        add(1, 8'h00, 8'h00, 0, 0);
        // wrap priority around requester 5 / 0
        add(1, 8'h20, 8'h20, 1, 0);
        add(1, 8'h00, 8'h00, 0, 0);
        add(1, 8'h21, 8'h01, 1, 0);
        add(1, 8'h00, 8'h00, 0, 0);
        add(1, 8'h21, 8'h20, 1, 0);
        add(1, 8'h00, 8'h00, 0, 0);
        // reset mid-grant, then rescan from ptr 0
        add(1, 8'hC0, 8'h40, 1, 0);
        add(1, 8'hC0, 8'h40, 1, 0);
        add(0, 8'hC0, 8'h00, 0, 0);
        add(1, 8'hC0, 8'h40, 1, 0);
        add(1, 8'h00, 8'h00, 0, 0);
        // release by requester 7 wraps ptr to 0
        add(1, 8'h81, 8'h80, 1, 0);
        add(1, 8'h00, 8'h00, 0, 0);
        add(1, 8'h81, 8'h01, 1, 0);
        add(1, 8'h00, 8'h00, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst_n;
            req16 = tbl[i].req;
            tick();
            chk16($sformatf("vec%0d", i), tbl[i].grant, tbl[i].vld, tbl[i].tmo);
        end

        // hold limit of 16, then re-grant of the same sole requester after one dead cycle
        req16 = 8'h02;
        for (int c = 0; c < 16; c++) begin
            tick();
            chk16($sformatf("hold16 c%0d", c), 8'h02, 1, 0);
        end
        tick();
        chk16("hold16 release", 8'h00, 0, 1);
        tick();
        chk16("hold16 regrant", 8'h02, 1, 0);
        req16 = 8'h00;
        tick();
        chk16("hold16 drop", 8'h00, 0, 0);

        // full rotation with MAX_HOLD=4
        req4 = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk4($sformatf("rot r%0d c%0d", r, c), 8'(1 << r), 1, 0);
            end
            tick();
            chk4($sformatf("rot r%0d dead", r), 8'h00, 0, 1);
        end
        tick();
        chk4("rot wrap", 8'h01, 1, 0);
        req4 = 8'h00;
        tick();
        chk4("rot drop", 8'h00, 0, 0);

        // requester 3 drops req exactly when the hold limit is reached
        req4 = 8'h08;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk4($sformatf("simul c%0d", c), 8'h08, 1, 0);
        end
        req4 = 8'h00;
        tick();
        chk4("simul release", 8'h00, 0, 0);
        req4 = 8'h18;
        tick();
        chk4("simul ptr4", 8'h10, 1, 0);
        req4 = 8'h00;
        tick();
        chk4("simul end", 8'h00, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- 8-requester round-robin arbiter. Sits directly upstream of the 8-to-3 one-hot encoder and drives that encoder's 8-bit input.
- Registered grant output is always either all-zero or exactly one-hot. The encoder therefore never sees a multi-hot code, which it maps to x.
- Holds each grant until the owner drops its request or a hold-time limit expires. Rotating priority prevents starvation.

Parameters:
- N, 8, number of requesters; grant width. The downstream encoder fixes this at 8.
- MAX_HOLD, 16, maximum consecutive cycles one grant may stay asserted; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  N  per-requester request level; a requester holds its bit high while it wants or owns the resource
- grant  output  N  registered grant, zero or one-hot; feeds the encoder input
- grant_valid  output  1  registered, equals |grant
- timeout  output  1  registered one-cycle pulse; current grant was force-released by MAX_HOLD

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only on the rising edge of clk.
- Reset values:
  - grant = 0, grant_valid = 0, timeout = 0
  - state = IDLE, ptr = 0, hold_cnt = 0
- Internal state:
  - ptr: priority pointer, log2(N) bits
  - hold_cnt: counter, wide enough for MAX_HOLD
  - FSM with states IDLE and OWN
- IDLE:
  - If req != 0, scan bits ptr, ptr+1, ..., ptr+N-1 (mod N). The first set bit g wins.
  - Next edge: grant = 1<<g, grant_valid = 1, hold_cnt = 1, state = OWN.
  - If req == 0, stay in IDLE with grant = 0.
  - Latency from req visible to grant visible is 1 cycle.
- OWN, with owner g:
  - Release condition: req[g] == 0, or hold_cnt == MAX_HOLD.
  - On release, at the next edge: grant = 0, grant_valid = 0, ptr = (g+1) mod N, hold_cnt = 0, state = IDLE.
  - Otherwise, hold_cnt increments and grant is unchanged.
  - Requests from other requesters are ignored while in OWN; there is no preemption.
- Dead cycle: at least one grant = 0 cycle always separates two grants, including a re-grant to the same requester. The encoder output is undefined in that cycle; consumers gate on grant_valid.
- timeout:
  - Asserted for exactly the one cycle following a release in which req[g] was still 1 and hold_cnt == MAX_HOLD. Otherwise 0.
  - If req[g] drops on the same edge that hold_cnt reaches MAX_HOLD, it is a normal release and timeout stays 0.
- Force-released requester: stays eligible, but has lowest priority in the next scan because ptr = g+1.
- Wrap-around: ptr = N-1 after a release by requester N-2. A release by N-1 wraps ptr to 0.
- Maximum grant length is exactly MAX_HOLD cycles. With MAX_HOLD = 1, every grant lasts 1 cycle and is followed by 1 idle cycle.
- Reset mid-grant: at that edge, grant and timeout clear, ptr returns to 0, state returns to IDLE, with no release side effects. req is ignored while rst_n = 0.
- Invariant: $onehot0(grant) holds every cycle. The bench asserts it.

Test Plan:
1. Reset: hold rst_n = 0 for 3 cycles with req = 8'hFF -> grant = 8'h00, grant_valid = 0, timeout = 0 throughout. Release reset with req = 8'hFF -> grant = 8'h01 one cycle later.
2. Single request, ptr = 0, MAX_HOLD = 16: req = 8'h04 for 5 cycles, then 8'h00 -> grant = 8'h04 from cycle 1 to cycle 5, grant = 8'h00 at cycle 6, ptr = 3, timeout never 1. The encoder sees 4'd4 and produces 3'd2 while valid.
3. Rotation with MAX_HOLD = 4: req = 8'hFF held constant -> grant sequence 01×4, 00, 02×4, 00, 04×4, ... 80×4, 00, then 01 again. timeout pulses once after each 4-cycle burst (8 pulses per round).
4. Wrap priority: after requester 5 releases (ptr = 6), apply req = 8'h21 -> grant = 8'h01, not 8'h20. After requester 0 releases (ptr = 1), grant = 8'h20.
5. Simultaneous release, MAX_HOLD = 4: requester 3 drops req on the same cycle hold_cnt reaches 4 -> grant = 8'h00 next cycle, timeout = 0, ptr = 4.
6. Reset mid-grant: while grant = 8'h40, pull rst_n low for 1 cycle with req = 8'hC0 held -> grant = 8'h00 at that edge. After reset releases, grant = 8'h40 (scan from ptr = 0 finds bit 6 first).
